// File: rtl/board_mem_arbiter_if.sv
// Bus bundle between the three board requesters, the board-RAM arbiter and the board RAM.
// The master side is the requester/RAM environment; the slave side is the arbiter.
interface board_mem_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [20:0] addr;
    logic [5:0]  wdata;
    logic [2:0]  lock;
    logic [2:0]  ack;
    logic [2:0]  rvalid;
    logic [1:0]  rdata;
    logic [6:0]  mem_addr;
    logic [1:0]  mem_data;
    logic        mem_wren;
    logic [1:0]  mem_q;
    logic        err;

    modport master (
        output req, we, addr, wdata, lock, mem_q,
        input  ack, rvalid, rdata, mem_addr, mem_data, mem_wren, err
    );

    modport slave (
        input  req, we, addr, wdata, lock, mem_q,
        output ack, rvalid, rdata, mem_addr, mem_data, mem_wren, err
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// Round-robin arbiter sharing the board RAM between initializer, flipper and renderer.
// Optional address bounds checking is built in when BOARD_ARB_BOUNDS_CHECK_EN is defined.
module board_mem_arbiter #(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned N_CELLS = 100
) (
    input  logic               clock,
    input  logic               reset,
    board_mem_arbiter_if.slave bus
);

    logic [2:0] ack_q, ack_d;
    logic [2:0] rvalid_q, rvalid_d;
    logic [1:0] rdata_q, rdata_d;
    logic [6:0] mem_addr_q, mem_addr_d;
    logic [1:0] mem_data_q, mem_data_d;
    logic       mem_wren_q, mem_wren_d;
    logic [1:0] last_q, last_d;
    logic [1:0] owner_q, owner_d;
    logic       owner_vld_q, owner_vld_d;
    logic       err_q, err_d;

    logic       pipe_vld_q [RD_LAT];
    logic [1:0] pipe_id_q  [RD_LAT];
    logic       pipe_oob_q [RD_LAT];

    logic [2:0] elig_s;
    logic [2:0] pick_s;
    logic       grant_s;
    logic [6:0] gnt_addr_s;
    logic [1:0] gnt_wdata_s;
    logic       gnt_we_s;
    logic       gnt_lock_s;
    logic       gnt_oob_s;
    logic       rd_issue_s;

    function automatic logic [1:0] rr_next(input logic [1:0] cur);
        case (cur)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    // Returns {found, index} of the first eligible requester after last.
    function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] c3;
        c1 = rr_next(last);
        c2 = rr_next(c1);
        c3 = rr_next(c2);
        if (elig[c1]) begin
            rr_pick = {1'b1, c1};
        end else if (elig[c2]) begin
            rr_pick = {1'b1, c2};
        end else if (elig[c3]) begin
            rr_pick = {1'b1, c3};
        end else begin
            rr_pick = 3'b000;
        end
    endfunction

    // Grant selection: a locked owner excludes everyone else, even while it is ineligible
    always_comb begin
        elig_s = bus.req & ~ack_q;
        pick_s = 3'b000;
        if (owner_vld_q && bus.lock[owner_q]) begin
            if (elig_s[owner_q]) begin
                pick_s = {1'b1, owner_q};
            end else begin
                pick_s = 3'b000;
            end
        end else begin
            pick_s = rr_pick(elig_s, last_q);
        end
    end

    assign grant_s = pick_s[2];

    // Unpack the request fields of the selected requester
    always_comb begin
        gnt_addr_s  = bus.addr[6:0];
        gnt_wdata_s = bus.wdata[1:0];
        gnt_we_s    = bus.we[0];
        gnt_lock_s  = bus.lock[0];
        case (pick_s[1:0])
            2'd1: begin
                gnt_addr_s  = bus.addr[13:7];
                gnt_wdata_s = bus.wdata[3:2];
                gnt_we_s    = bus.we[1];
                gnt_lock_s  = bus.lock[1];
            end
            2'd2: begin
                gnt_addr_s  = bus.addr[20:14];
                gnt_wdata_s = bus.wdata[5:4];
                gnt_we_s    = bus.we[2];
                gnt_lock_s  = bus.lock[2];
            end
            default: gnt_addr_s = bus.addr[6:0];
        endcase
    end

`ifdef BOARD_ARB_BOUNDS_CHECK_EN
    assign gnt_oob_s = grant_s && ({25'd0, gnt_addr_s} >= N_CELLS);
`else
    assign gnt_oob_s = 1'b0;
`endif

    assign rd_issue_s = grant_s & ~gnt_we_s;

    // Next-state for RAM-side outputs, handshake pulses, RR pointer and bus ownership
    always_comb begin
        ack_d       = 3'b000;
        rvalid_d    = 3'b000;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_wren_d  = 1'b0;
        last_d      = last_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        err_d       = err_q;

        if (owner_vld_q && !bus.lock[owner_q]) begin
            owner_vld_d = 1'b0;
        end else begin
            owner_vld_d = owner_vld_q;
        end

        if (grant_s) begin
            ack_d      = 3'b001 << pick_s[1:0];
            last_d     = pick_s[1:0];
            mem_data_d = gnt_wdata_s;
            if (gnt_oob_s) begin
                mem_addr_d = mem_addr_q;
                mem_wren_d = 1'b0;
                err_d      = 1'b1;
            end else begin
                mem_addr_d = gnt_addr_s;
                mem_wren_d = gnt_we_s;
            end
            if (gnt_lock_s) begin
                owner_d     = pick_s[1:0];
                owner_vld_d = 1'b1;
            end else begin
                owner_d = owner_q;
            end
        end else begin
            mem_wren_d = 1'b0;
        end

        // Out-of-range reads return the border code instead of RAM data
        if (pipe_vld_q[RD_LAT-1]) begin
            rvalid_d = 3'b001 << pipe_id_q[RD_LAT-1];
            rdata_d  = pipe_oob_q[RD_LAT-1] ? 2'b11 : bus.mem_q;
        end else begin
            rvalid_d = 3'b000;
        end
    end

    // Output and control registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            ack_q       <= 3'b000;
            rvalid_q    <= 3'b000;
            rdata_q     <= 2'b00;
            mem_addr_q  <= 7'd0;
            mem_data_q  <= 2'b00;
            mem_wren_q  <= 1'b0;
            last_q      <= 2'd2;
            owner_q     <= 2'd0;
            owner_vld_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_wren_q  <= mem_wren_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            err_q       <= err_d;
        end
    end

    // Read-return pipeline carrying the issuing requester and out-of-range flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_id_q[k]  <= 2'd0;
                pipe_oob_q[k] <= 1'b0;
            end
        end else begin
            pipe_vld_q[0] <= rd_issue_s;
            pipe_id_q[0]  <= pick_s[1:0];
            pipe_oob_q[0] <= gnt_oob_s;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_id_q[k]  <= pipe_id_q[k-1];
                pipe_oob_q[k] <= pipe_oob_q[k-1];
            end
        end
    end

    assign bus.ack      = ack_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.mem_wren = mem_wren_q;
    assign bus.err      = err_q;

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Shares the single 100-entry board RAM (7-bit address, 2-bit cell code) between three requesters: 0 = board initializer, 1 = move validator/flipper, 2 = display renderer.
- Arbitrates round-robin, with an optional bus lock for multi-access sequences such as flipping a line of pieces.
- Registers all RAM-side signals and routes read data back to the requester that issued the read.
- Sits between the game-control logic and the board altsyncram.

Parameters:
- RD_LAT, 1, RAM read latency in clocks: edges from the edge that registers mem_addr to the edge where mem_q is valid (1 to 3).
- N_CELLS, 100, number of valid board addresses (10x10 including border).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- req  in  3  per-requester access request, held until ack
- we  in  3  per-requester write enable (1 = write, 0 = read); held with req
- addr  in  21  packed addresses, requester i at [7i+6:7i]
- wdata  in  6  packed write data, requester i at [2i+1:2i]
- lock  in  3  per-requester bus lock
- ack  out  3  one-cycle grant pulse
- rvalid  out  3  one-cycle read-data-valid pulse
- rdata  out  2  read data, shared; qualified by rvalid
- mem_addr  out  7  RAM address
- mem_data  out  2  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  2  RAM read data
- err  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset (reset == 0 at an edge):
  - ack, rvalid, mem_wren and err go to 0; mem_addr, mem_data and rdata go to 0.
  - Read pipeline is flushed; in-flight reads are discarded and never return rvalid.
  - RR pointer last = 2, so requester 0 has top priority first.
- Eligibility: req[i] == 1 and ack[i] == 0. A requester is never granted in the cycle its ack is high, which prevents double issue. Each requester is limited to one access per 2 cycles; different requesters may be granted back to back.
- Arbitration at each edge, evaluated on current inputs:
  - If owner valid and lock[owner] == 1: only owner may be granted. If owner is ineligible this cycle, the bus idles (no grant, mem_wren = 0).
  - Else: grant the first eligible index searching last+1, last+2, last+3 (mod 3).
- Grant of requester g at edge G:
  - ack[g] = 1 for the cycle after G; last <= g.
  - mem_addr <= addr[g]; mem_data <= wdata[g]; mem_wren <= we[g].
  - owner <= g if lock[g] == 1.
  - Owner is released on the first edge where lock[owner] == 0.
- No grant at an edge: mem_wren <= 0; mem_addr and mem_data hold.
- Read return:
  - A pipeline of RD_LAT stages carries {valid, id}, entered at G when we[g] == 0.
  - At edge G+RD_LAT: rdata <= mem_q, and rvalid[id] = 1 for the following cycle.
  - With RD_LAT = 1, rvalid coincides with the cycle after the ack cycle.
  - Reads never stall; returns are in issue order.
- Writes produce no rvalid.
- Simultaneous events:
  - At most one ack bit and one rvalid bit are high per cycle.
  - Grant and read return in the same cycle are independent.
- lock asserted by a non-owner while another requester owns the bus has no effect until release.

Optional Feature:
- Macro BOARD_ARB_BOUNDS_CHECK_EN.
- Defined:
  - A granted access with addr >= N_CELLS is still acked. mem_wren is forced to 0 and mem_addr holds its previous value.
  - A read of such an address returns rdata = 2'b11 (border code) with normal rvalid timing.
  - err is set to 1 and stays set until reset.
- Undefined: addresses pass to the RAM unchecked; err is tied to 0.

Test Plan:
- Reset, then req = 3'b111, all reads, addr 0/44/55, lock = 0 -> ack order 001, 010, 100 on consecutive cycles; rvalid follows in the same order, RD_LAT cycles later, with rdata = RAM contents.
- Requester 1 writes addr 45 data 2'b10 and holds req continuously, requester 2 idle -> ack[1] high every other cycle only; mem_wren = 1 with mem_addr = 45 and mem_data = 2'b10 on the ack cycles.
- Requester 1 holds lock = 1 for 4 accesses while req[0] and req[2] stay high -> only ack[1] pulses, with idle gaps between. After lock drops, the next grant goes to requester 2, then requester 0.
- RD_LAT = 2: read by requester 2, then reset = 0 one cycle after its ack -> no rvalid; all outputs 0. After reset release, req[0] is granted first.
- BOARD_ARB_BOUNDS_CHECK_EN defined: requester 0 reads addr 120 -> ack, rvalid with rdata = 2'b11, err = 1. Then a write to addr 101 -> mem_wren stays 0; err remains 1.
